serial_alu_sequencer: RTL and testbench
=======================================

# serial_alu_sequencer

Bit-serial sequencer for the 1-bit ALU logic slice: accepts WIDTH-bit operands and an opcode, feeds one bit pair per cycle (LSB first) into the external slice, and chains the slice carry-out back as the next carry-in. It reassembles the slice results into a WIDTH-bit word and signals completion. It sits directly upstream of the slice, driving its operand/opsel/carry inputs, and directly downstream of it, consuming its result/carry outputs.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand 1, latched on accepted start
- b  input  WIDTH  operand 2, latched on accepted start
- op  input  3  opcode, latched on accepted start; drives slice opsel unchanged
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result/cout valid
- result  output  WIDTH  assembled result, held until next accepted start
- cout  output  1  final slice carry-out, held with result
- slice_op1  output  1  current bit of a
- slice_op2  output  1  current bit of b
- slice_opsel  output  3  latched op
- slice_cin  output  1  carry into current bit
- slice_result  input  1  slice result for current bit (combinational from slice_* outputs)
- slice_cout  input  1  slice carry-out for current bit

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOT a, 1xx shift-left-by-1 (slice passes carry-in to result, carry-out = op1). Sequencer does not decode op; it only forwards it.
- FSM IDLE → RUN → DONE → IDLE.
- IDLE: slice_op1/op2/cin/opsel driven 0. On start=1: latch a, b, op into shift registers; clear carry register; bit counter ← 0; → RUN.
- RUN, each cycle: slice_op1=a_sh[0], slice_op2=b_sh[0], slice_cin=carry reg. At the edge: result_sh ← {slice_result, result_sh[WIDTH-1:1]}; carry ← slice_cout; a_sh, b_sh shift right; counter++. After bit WIDTH-1 captured → DONE.
- Initial carry-in is 0 (shift-in bit for SHL). For logic ops the slice returns cout 0 every bit; cout output is 0.
- DONE: done=1, busy=1, result/cout valid; → IDLE unconditionally. start ignored.
- start while busy is ignored (no queueing). Input changes after acceptance have no effect.
- result and cout stay stable in IDLE until the next accepted start clears result_sh.

## Timing
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, result=0, cout=0, counter=0, all slice_* outputs 0. Reset overrides start and aborts RUN/DONE at any point; no done pulse for the aborted operation.
- Start accepted at edge k → busy=1 from cycle k+1; bits 0..WIDTH-1 captured at edges k+1..k+WIDTH; done=1 for cycle k+WIDTH+1 only; next start accepted at edge k+WIDTH+2 earliest.
- Throughput: one operation per WIDTH+2 cycles.
- Counter width $clog2(WIDTH); compare against WIDTH-1, no wrap in normal operation.
- All outputs registered except slice_op1/op2/cin/opsel, which are direct register bits (no combinational path from inputs).

## Structure
- Package serial_alu_pkg: op_t enum (OP_AND=3'b000, OP_OR=3'b001, OP_XOR=3'b010, OP_NOT=3'b011, OP_SHL=3'b100), state_t enum (IDLE, RUN, DONE).
- One natural sub-module: serial_shreg (WIDTH-bit load / shift-right / serial-in register), instantiated for a, b and result.
- Slice itself is instantiated outside this block; bench uses the real slice.

## Test plan
- WIDTH=8, op=000, a=0xA5, b=0x3C, start at edge k → done pulse exactly at cycle k+9, result=0x24, cout=0, busy low at k+10.
- op=010, a=0xFF, b=0x0F → result=0xF0; op=001, a=0x12, b=0x40 → result=0x52.
- op=011, a=0x5A, b=0xFF → result=0xA5, cout=0.
- op=100, a=0x81 → result=0x02, cout=1; a=0x40 → result=0x80, cout=0.
- start held high and a/b changed during RUN → single done, result from values latched at acceptance; back-to-back starts spaced WIDTH+2 cycles both complete.
- rst=1 at bit 3 of a RUN → next cycle busy=0, done=0, result=0, slice_* = 0; following op=000, a=b=0xFF → result=0xFF.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: opcode encodings and FSM states.
package serial_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_XOR = 3'b010,
    OP_NOT = 3'b011,
    OP_SHL = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_alu_sequencer_shreg.sv
// WIDTH-bit register with parallel load and right shift taking a serial bit in at the MSB.
module serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // A load wins over a shift so an accepted start always begins from fresh operands.
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= load_val;
    else if (shift)
      q <= {sin, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Feeds operands LSB-first through an external 1-bit ALU slice, chaining its carry
// and reassembling the serial results into a WIDTH-bit word.
module serial_alu_sequencer
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             slice_op1,
  output logic             slice_op2,
  output logic [2:0]       slice_opsel,
  output logic             slice_cin,
  input  logic             slice_result,
  input  logic             slice_cout
);

  localparam int CW = $clog2(WIDTH);

  state_t         state, next_state;
  logic [CW-1:0]  count;
  logic           carry;
  op_t            op_q;
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic           accept, running, last_bit;
  logic           unused_bits;

  assign accept   = (state == IDLE) && start;
  assign running  = (state == RUN);
  assign last_bit = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Slice drives are forced low outside RUN so the slice sees a quiet bus when idle.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    slice_op1   = 1'b0;
    slice_op2   = 1'b0;
    slice_cin   = 1'b0;
    slice_opsel = 3'b000;
    case (state)
      RUN: begin
        busy        = 1'b1;
        slice_op1   = a_q[0];
        slice_op2   = b_q[0];
        slice_cin   = carry;
        slice_opsel = op_q;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter saturates at the last bit so it never wraps while waiting in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      carry <= 1'b0;
      op_q  <= OP_AND;
    end else if (accept) begin
      count <= '0;
      carry <= 1'b0;
      op_q  <= op_t'(op);
    end else if (running) begin
      carry <= slice_cout;
      if (!last_bit)
        count <= count + 1'b1;
    end
  end

  serial_shreg #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val(a),
    .shift(running), .sin(1'b0), .q(a_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val(b),
    .shift(running), .sin(1'b0), .q(b_q)
  );

  serial_shreg #(.WIDTH(WIDTH)) u_r_sh (
    .clk(clk), .rst(rst), .load(accept), .load_val('0),
    .shift(running), .sin(slice_result), .q(r_q)
  );

  assign result = r_q;
  assign cout   = carry;

  // Only the LSB of each operand register feeds the slice.
  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer driving a behavioural 1-bit ALU slice.
module tb_serial_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [2:0] op = 3'b000;
  logic       busy, done, cout;
  logic [7:0] result;
  logic       slice_op1, slice_op2, slice_cin, slice_result, slice_cout;
  logic [2:0] slice_opsel;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_alu_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .slice_op1(slice_op1), .slice_op2(slice_op2), .slice_opsel(slice_opsel),
    .slice_cin(slice_cin), .slice_result(slice_result), .slice_cout(slice_cout)
  );

  // Behavioural 1-bit ALU slice sitting outside the sequencer.
  always_comb begin
    slice_result = 1'b0;
    slice_cout   = 1'b0;
    if (slice_opsel[2]) begin
      slice_result = slice_cin;
      slice_cout   = slice_op1;
    end else begin
      case (slice_opsel[1:0])
        2'b00:   slice_result = slice_op1 & slice_op2;
        2'b01:   slice_result = slice_op1 | slice_op2;
        2'b10:   slice_result = slice_op1 ^ slice_op2;
        default: slice_result = ~slice_op1;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit hold);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 20);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] exp_r, input logic exp_c);
    int lat;
    applyStimulus(o, x, y, 1'b0);
    wait_done(lat);
    checkOutput({tag, "_latency"}, lat, 8);
    checkOutput({tag, "_result"}, {24'd0, result}, {24'd0, exp_r});
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_result", {24'd0, result}, 32'd0);
    checkOutput("rst_cout", {31'd0, cout}, 32'd0);
    checkOutput("rst_slice", {26'd0, slice_op1, slice_op2, slice_cin, slice_opsel}, 32'd0);
    rst = 1'b0;

    run_op("and", 3'b000, 8'hA5, 8'h3C, 8'h24, 1'b0);
    run_op("xor", 3'b010, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    run_op("or",  3'b001, 8'h12, 8'h40, 8'h52, 1'b0);
    run_op("not", 3'b011, 8'h5A, 8'hFF, 8'hA5, 1'b0);
    run_op("shl_81", 3'b100, 8'h81, 8'h00, 8'h02, 1'b1);
    run_op("shl_40", 3'b100, 8'h40, 8'h00, 8'h80, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_hold_result", {24'd0, result}, 32'h80);

    // Start held high with operands changing during RUN.
    applyStimulus(3'b010, 8'h33, 8'h0F, 1'b1);
    checkOutput("run_opsel", {29'd0, slice_opsel}, 32'd2);
    checkOutput("run_op1_bit0", {31'd0, slice_op1}, 32'd1);
    checkOutput("run_op2_bit0", {31'd0, slice_op2}, 32'd1);
    a = 8'hFF; b = 8'hFF; op = 3'b000;
    wait_done(lat);
    start = 1'b0;
    checkOutput("held_latency", lat, 8);
    checkOutput("held_result", {24'd0, result}, 32'h3C);
    @(posedge clk);
    #1;
    checkOutput("held_busy_off", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held_no_restart", {31'd0, busy}, 32'd0);

    // Back-to-back: second start raised the moment done appears.
    applyStimulus(3'b000, 8'hF0, 8'h3C, 1'b0);
    wait_done(lat);
    checkOutput("b2b1_latency", lat, 8);
    checkOutput("b2b1_result", {24'd0, result}, 32'h30);
    op = 3'b001; a = 8'h01; b = 8'h80; start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("b2b_ignore_in_done", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b2_accepted", {31'd0, busy}, 32'd1);
    wait_done(lat);
    checkOutput("b2b2_latency", lat, 8);
    checkOutput("b2b2_result", {24'd0, result}, 32'h81);

    // Reset during bit 3 of a run aborts it.
    applyStimulus(3'b000, 8'hA5, 8'h3C, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_result", {24'd0, result}, 32'd0);
    checkOutput("abort_cout", {31'd0, cout}, 32'd0);
    checkOutput("abort_slice", {26'd0, slice_op1, slice_op2, slice_cin, slice_opsel}, 32'd0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);

    run_op("post_rst", 3'b000, 8'hFF, 8'hFF, 8'hFF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
